sram_axi_arbiter: RTL and testbench
===================================

SRAM_AXI_ARBITER -- requirements
Module: sram_axi_arbiter

Interface
REQ-001 Parameter INST_BURST_LEN, default 3: the arlen value used for an instruction burst read (cache-line refill of 4 beats).
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req / inst_burst / inst_addr / inst_size  input  1/1/32/2  instruction read request; inst_burst=1 selects an INST_BURST_LEN burst.
REQ-005 inst_addr_ok / inst_data_ok / inst_rlast  output  1/1/1  request accepted / one read beat valid / that beat is the last.
REQ-006 inst_rdata  output  32  read beat data.
REQ-007 data_req / data_wr / data_size / data_wstrb  input  1/1/2/4  data request, write flag, size, byte strobes.
REQ-008 data_addr / data_wdata  input  32/32  data address and write data.
REQ-009 data_addr_ok / data_data_ok  output  1/1  data request accepted / read data valid or write response received.
REQ-010 data_rdata  output  32  data read result.
REQ-011 arid/araddr/arlen/arsize/arvalid  output  4/32/8/3/1; arready  input  1  AXI read address channel.
REQ-012 rid/rdata/rlast/rvalid  input  4/32/1/1; rready  output  1  AXI read data channel.
REQ-013 awaddr/awsize/awvalid  output  32/3/1; awready  input  1  AXI write address channel.
REQ-014 wdata/wstrb/wvalid  output  32/4/1; wready  input  1  AXI write data channel.
REQ-015 bvalid  input  1; bready  output  1  AXI write response channel.
REQ-016 The constant AXI fields SHALL be: arburst/awburst=01, lock/cache/prot=0, awid/wid=1, awlen=0, wlast=1. arsize and awsize SHALL be {1'b0,size}.

Function
REQ-017 The read FSM SHALL use the states R_IDLE, R_ADDR and R_DATA. The write FSM SHALL use the states W_IDLE, W_ADDR and W_RESP. The two FSMs SHALL run independently.
REQ-018 In R_IDLE, a data read (data_req & ~data_wr) SHALL be granted only when the write FSM is in W_IDLE. Otherwise inst_req SHALL be granted. A grantable data read SHALL win over inst_req when both are present in the same cycle.
REQ-019 On a grant, the block SHALL pulse the matching *_addr_ok for 1 cycle, combinationally in the grant cycle, and SHALL latch addr, size, id (0=inst, 1=data) and len (INST_BURST_LEN if inst_burst, else 0). The next state SHALL be R_ADDR.
REQ-020 In R_ADDR, arvalid SHALL be 1 and driven from registers only. On arready the FSM SHALL move to R_DATA.
REQ-021 In R_DATA, rready SHALL be 1. On each beat with rvalid & rid==latched id, the owner's data_ok SHALL be 1 in the same cycle and rdata SHALL pass through unregistered. inst_rlast SHALL equal rlast. On rlast the FSM SHALL return to R_IDLE, with no idle bubble required before the next grant.
REQ-022 Beats with a mismatched rid SHALL be consumed with no *_data_ok.
REQ-023 In W_IDLE, a data write SHALL be accepted (data_addr_ok pulse, addr/wdata/wstrb/size latched) unless the read FSM currently owns a data read (latched id=1, state ≠ R_IDLE). This preserves data_ok ordering.
REQ-024 In W_ADDR, awvalid and wvalid SHALL be asserted independently. Each SHALL drop after its own handshake, tracked by aw_done and w_done flags. When both are done, including in the same cycle, the FSM SHALL move to W_RESP.
REQ-025 In W_RESP, bready SHALL be 1. On bvalid the block SHALL pulse data_data_ok for 1 cycle and return to W_IDLE.
REQ-026 A data write and an inst read requested in the same cycle SHALL both be accepted.
REQ-027 data_addr_ok SHALL never be asserted for both a read and a write in one cycle.
REQ-028 A valid signal, once raised, SHALL stay high with stable payload until its handshake completes.
REQ-029 data_rdata SHALL be 0 whenever data_data_ok is not caused by a read beat.

Reset
REQ-030 Reset SHALL force R_IDLE and W_IDLE and clear aw_done, w_done and the latched id, addr and len. From the first cycle after reset, every valid/ready/ok output SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no further *_ok pulse.

Structure
REQ-032 A shared package SHALL hold the R_*/W_* state encodings, the ID_INST=0 and ID_DATA=1 constants and the fixed AXI field constants.
REQ-033 One sub-module, axi_wr_channel, SHALL contain the write FSM and the AW/W/B handshakes. The read FSM and arbitration SHALL stay in the top.

Verification
REQ-034 Scenario: simultaneous inst_req and data read at 0x1000 in R_IDLE -> data_addr_ok=1, inst_addr_ok=0, araddr=0x1000, arid=1; inst is granted after rlast.
REQ-035 Scenario: inst_burst=1 at 0x1c000000 with 4 beats and rvalid gaps -> arlen=3, 4 inst_data_ok pulses, inst_rlast on the 4th only.
REQ-036 Scenario: write to 0x2000, wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds; data_data_ok 1 cycle after bvalid.
REQ-037 Scenario: data read issued while the write FSM is in W_RESP -> no data_addr_ok until the cycle the write FSM is back in W_IDLE.
REQ-038 Scenario: reset asserted in R_DATA mid-burst -> next cycle rready=0, arvalid=0 and no inst_data_ok on subsequent rvalid.

Source files
------------

// File: rtl/sram_axi_arbiter_pkg.sv
// sram_axi_arbiter_pkg: FSM encodings, transaction ids and fixed AXI fields
package sram_axi_arbiter_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT = 3'b000;
  localparam logic [3:0] AXI_WID = 4'd1;
  localparam logic [7:0] AXI_AWLEN = 8'd0;
endpackage

// File: rtl/axi_wr_channel.sv
// axi_wr_channel: single-beat write FSM with independent AW/W handshakes and B response
module axi_wr_channel
  import sram_axi_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rd_busy,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  strb,
  input  logic [1:0]  size,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        idle,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  w_state_t w_state;
  logic aw_done, w_done, aw_hs, w_hs;
  assign idle = w_state == W_IDLE;
  assign addr_ok = ~reset & idle & req & ~rd_busy;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      data_ok <= 1'b0;
      awaddr <= '0;
      awsize <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else begin
      data_ok <= 1'b0;
      case (w_state)
        W_IDLE: if (addr_ok) begin
          awaddr <= addr;
          awsize <= {1'b0, size};
          wdata <= din;
          wstrb <= strb;
          awvalid <= 1'b1;
          wvalid <= 1'b1;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          w_state <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            bready <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          bready <= 1'b0;
          data_ok <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: arbitrates inst/data SRAM-style requests onto one AXI master port
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter logic [7:0] INST_BURST_LEN = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_burst,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic        inst_rlast,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  r_state_t r_state;
  logic data_gnt, inst_gnt, beat, rd_data_ok, w_idle, wr_addr_ok, wr_data_ok;
  assign arburst = AXI_BURST_INCR;
  assign arlock = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot = AXI_PROT;
  assign awid = AXI_WID;
  assign awlen = AXI_AWLEN;
  assign awburst = AXI_BURST_INCR;
  assign awlock = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot = AXI_PROT;
  assign wid = AXI_WID;
  assign wlast = 1'b1;
  // a data read waits for the write side to drain so data_data_ok stays in order
  assign data_gnt = ~reset & r_state == R_IDLE & data_req & ~data_wr & w_idle;
  assign inst_gnt = ~reset & r_state == R_IDLE & ~data_gnt & inst_req;
  assign beat = r_state == R_DATA & rvalid & rid == arid;
  assign inst_data_ok = beat & arid == ID_INST;
  assign rd_data_ok = beat & arid == ID_DATA;
  assign inst_rlast = rlast;
  assign inst_rdata = rdata;
  assign data_rdata = rd_data_ok ? rdata : 32'd0;
  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt | wr_addr_ok;
  assign data_data_ok = rd_data_ok | wr_data_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      arid <= ID_INST;
      araddr <= '0;
      arlen <= '0;
      arsize <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (data_gnt | inst_gnt) begin
          arid <= data_gnt ? ID_DATA : ID_INST;
          araddr <= data_gnt ? data_addr : inst_addr;
          arsize <= {1'b0, data_gnt ? data_size : inst_size};
          arlen <= inst_gnt & inst_burst ? INST_BURST_LEN : 8'd0;
          arvalid <= 1'b1;
          r_state <= R_ADDR;
        end
        R_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: if (beat & rlast) begin
          rready <= 1'b0;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
  axi_wr_channel u_wr (
    .clk(clk),
    .reset(reset),
    .req(data_req & data_wr),
    .rd_busy(r_state != R_IDLE && arid == ID_DATA),
    .addr(data_addr),
    .din(data_wdata),
    .strb(data_wstrb),
    .size(data_size),
    .addr_ok(wr_addr_ok),
    .data_ok(wr_data_ok),
    .idle(w_idle),
    .awaddr(awaddr),
    .awsize(awsize),
    .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata),
    .wstrb(wstrb),
    .wvalid(wvalid),
    .wready(wready),
    .bvalid(bvalid),
    .bready(bready)
  );
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: directed scenarios with hand-computed expectations
module tb_sram_axi_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_req = 0, inst_burst = 0, data_req = 0, data_wr = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, rdata = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [3:0] data_wstrb = 0, rid = 0;
  logic arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic inst_addr_ok, inst_data_ok, inst_rlast, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, araddr, awaddr, wdata;
  logic [3:0] arid, arcache, awid, awcache, wid, wstrb;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;
  logic arvalid, rready, awvalid, wlast, wvalid, bready;
  int n_cmp = 0, n_bad = 0;

  sram_axi_arbiter #(.INST_BURST_LEN(8'd3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_burst(inst_burst), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rlast(inst_rlast), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    #1;
    n_cmp++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 000000000", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    n_cmp++;
    if ({arburst, awburst, awlen, wlast, awid, wid, arlock, arcache, arprot} !== {2'b01, 2'b01, 8'h00, 1'b1, 4'h1, 4'h1, 2'b00, 4'h0, 3'h0}) begin
      n_bad++;
      $display("FAIL const_fields: got %h want %h", {arburst, awburst, awlen, wlast, awid, wid, arlock, arcache, arprot}, {2'b01, 2'b01, 8'h00, 1'b1, 4'h1, 4'h1, 2'b00, 4'h0, 3'h0});
    end
  endtask

  task automatic test_priority();
    inst_req = 1; inst_burst = 0; inst_addr = 32'h1c00_0100; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h1000; data_size = 2;
    #1;
    n_cmp++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL prio_grant: got %b want 10", {data_addr_ok, inst_addr_ok});
    end
    step();
    data_req = 0;
    #1;
    n_cmp++;
    if ({arvalid, araddr, arid, arlen, arsize, inst_addr_ok} !== {1'b1, 32'h1000, 4'd1, 8'd0, 3'b010, 1'b0}) begin
      n_bad++;
      $display("FAIL prio_ar: got %h want %h", {arvalid, araddr, arid, arlen, arsize, inst_addr_ok}, {1'b1, 32'h1000, 4'd1, 8'd0, 3'b010, 1'b0});
    end
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rid = 1; rdata = 32'hdead_beef; rlast = 1;
    #1;
    n_cmp++;
    if ({arvalid, rready, data_data_ok, inst_data_ok, inst_addr_ok, data_rdata} !== {5'b01100, 32'hdead_beef}) begin
      n_bad++;
      $display("FAIL prio_beat: got %h want %h", {arvalid, rready, data_data_ok, inst_data_ok, inst_addr_ok, data_rdata}, {5'b01100, 32'hdead_beef});
    end
    step();
    rvalid = 0; rlast = 0;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_data_ok, data_rdata} !== {2'b10, 32'd0}) begin
      n_bad++;
      $display("FAIL prio_inst_next: got %h want %h", {inst_addr_ok, data_data_ok, data_rdata}, {2'b10, 32'd0});
    end
    step();
    inst_req = 0;
    #1;
    n_cmp++;
    if ({arvalid, araddr, arid} !== {1'b1, 32'h1c00_0100, 4'd0}) begin
      n_bad++;
      $display("FAIL prio_inst_ar: got %h want %h", {arvalid, araddr, arid}, {1'b1, 32'h1c00_0100, 4'd0});
    end
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rid = 0; rdata = 32'h0000_0013; rlast = 1;
    #1;
    n_cmp++;
    if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'h13, 1'b0}) begin
      n_bad++;
      $display("FAIL prio_inst_beat: got %h want %h", {inst_data_ok, inst_rdata, data_data_ok}, {1'b1, 32'h13, 1'b0});
    end
    step();
    rvalid = 0; rlast = 0;
  endtask

  task automatic test_burst();
    logic [7:0] rv_pat;
    logic [3:0] rid_pat [8];
    int beats;
    rv_pat = 8'b1010_1101;
    rid_pat = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    beats = 0;
    inst_req = 1; inst_burst = 1; inst_addr = 32'h1c00_0000; inst_size = 2;
    #1;
    n_cmp++;
    if (inst_addr_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_grant: got %b want 1", inst_addr_ok);
    end
    step();
    inst_req = 0; inst_burst = 0;
    #1;
    n_cmp++;
    if ({arlen, araddr, arid} !== {8'd3, 32'h1c00_0000, 4'd0}) begin
      n_bad++;
      $display("FAIL burst_ar: got %h want %h", {arlen, araddr, arid}, {8'd3, 32'h1c00_0000, 4'd0});
    end
    arready = 1;
    step();
    arready = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid = rv_pat[i];
      rid = rid_pat[i];
      rdata = 32'h100 + i;
      rlast = rv_pat[i] && rid_pat[i] == 0 && beats == 3;
      #1;
      n_cmp++;
      if ({inst_data_ok, inst_rlast, data_data_ok} !== {rvalid && rid == 0, rlast, 1'b0}) begin
        n_bad++;
        $display("FAIL burst_beat%0d: got %b want %b", i, {inst_data_ok, inst_rlast, data_data_ok}, {rvalid && rid == 0, rlast, 1'b0});
      end
      if (inst_data_ok) begin
        beats++;
        n_cmp++;
        if (inst_rdata !== 32'h100 + i) begin
          n_bad++;
          $display("FAIL burst_rdata%0d: got %h want %h", i, inst_rdata, 32'h100 + i);
        end
      end
      step();
    end
    rvalid = 0; rlast = 0; rid = 0;
    #1;
    n_cmp++;
    if ({beats[3:0], rready, arvalid} !== {4'd4, 2'b00}) begin
      n_bad++;
      $display("FAIL burst_done: got %h want %h", {beats[3:0], rready, arvalid}, {4'd4, 2'b00});
    end
  endtask

  task automatic test_write();
    data_req = 1; data_wr = 1; data_addr = 32'h2000; data_wdata = 32'hcafe_f00d; data_wstrb = 4'hf; data_size = 2;
    #1;
    n_cmp++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL wr_accept: got %b want 10", {data_addr_ok, inst_addr_ok});
    end
    step();
    data_req = 0; data_wr = 0;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, awaddr, awsize, wdata, wstrb} !== {2'b11, 32'h2000, 3'b010, 32'hcafe_f00d, 4'hf}) begin
      n_bad++;
      $display("FAIL wr_payload: got %h want %h", {awvalid, wvalid, awaddr, awsize, wdata, wstrb}, {2'b11, 32'h2000, 3'b010, 32'hcafe_f00d, 4'hf});
    end
    wready = 1;
    step();
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h2000}) begin
        n_bad++;
        $display("FAIL wr_aw_hold%0d: got %h want %h", i, {awvalid, wvalid, bready, awaddr}, {3'b100, 32'h2000});
      end
      if (i == 2) awready = 1;
      step();
    end
    awready = 0;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin
      n_bad++;
      $display("FAIL wr_resp_wait: got %b want 0010", {awvalid, wvalid, bready, data_data_ok});
    end
    bvalid = 1;
    #1;
    n_cmp++;
    if (data_data_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_ok_early: got %b want 0", data_data_ok);
    end
    step();
    bvalid = 0;
    #1;
    n_cmp++;
    if ({data_data_ok, bready, data_rdata} !== {2'b10, 32'd0}) begin
      n_bad++;
      $display("FAIL wr_ok: got %h want %h", {data_data_ok, bready, data_rdata}, {2'b10, 32'd0});
    end
    step();
    n_cmp++;
    if (data_data_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_ok_pulse: got %b want 0", data_data_ok);
    end
  endtask

  task automatic test_concurrent();
    inst_req = 1; inst_burst = 0; inst_addr = 32'h1c00_0040; inst_size = 2;
    data_req = 1; data_wr = 1; data_addr = 32'h2004; data_wdata = 32'h5555_aaaa; data_wstrb = 4'h3; data_size = 1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin
      n_bad++;
      $display("FAIL conc_accept: got %b want 11", {inst_addr_ok, data_addr_ok});
    end
    step();
    inst_req = 0; data_req = 0; data_wr = 0;
    arready = 1; awready = 1; wready = 1;
    #1;
    n_cmp++;
    if ({arvalid, awvalid, wvalid, awsize, wstrb} !== {3'b111, 3'b001, 4'h3}) begin
      n_bad++;
      $display("FAIL conc_valid: got %h want %h", {arvalid, awvalid, wvalid, awsize, wstrb}, {3'b111, 3'b001, 4'h3});
    end
    step();
    arready = 0; awready = 0; wready = 0;
    rvalid = 1; rid = 0; rdata = 32'h77; rlast = 1; bvalid = 1;
    #1;
    n_cmp++;
    if ({rready, bready, inst_data_ok, data_data_ok} !== 4'b1110) begin
      n_bad++;
      $display("FAIL conc_resp: got %b want 1110", {rready, bready, inst_data_ok, data_data_ok});
    end
    step();
    rvalid = 0; rlast = 0; bvalid = 0;
    #1;
    n_cmp++;
    if ({data_data_ok, inst_data_ok, rready, bready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL conc_done: got %b want 1000", {data_data_ok, inst_data_ok, rready, bready});
    end
    step();
  endtask

  task automatic test_rd_blocked();
    data_req = 1; data_wr = 1; data_addr = 32'h2008; data_wdata = 32'h1; data_wstrb = 4'h1; data_size = 0;
    step();
    data_wr = 0; data_addr = 32'h3000; data_size = 2;
    awready = 1; wready = 1;
    #1;
    n_cmp++;
    if (data_addr_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL blk_waddr: got %b want 0", data_addr_ok);
    end
    step();
    awready = 0; wready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({data_addr_ok, inst_addr_ok, bready} !== 3'b001) begin
        n_bad++;
        $display("FAIL blk_wresp%0d: got %b want 001", i, {data_addr_ok, inst_addr_ok, bready});
      end
      if (i == 1) bvalid = 1;
      else step();
    end
    #1;
    n_cmp++;
    if (data_addr_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL blk_bvalid: got %b want 0", data_addr_ok);
    end
    step();
    bvalid = 0;
    #1;
    n_cmp++;
    if ({data_addr_ok, data_data_ok, data_rdata} !== {2'b11, 32'd0}) begin
      n_bad++;
      $display("FAIL blk_release: got %h want %h", {data_addr_ok, data_data_ok, data_rdata}, {2'b11, 32'd0});
    end
    step();
    data_wr = 1; data_addr = 32'h4000;
    #1;
    n_cmp++;
    if ({data_addr_ok, arid, araddr, awvalid} !== {1'b0, 4'd1, 32'h3000, 1'b0}) begin
      n_bad++;
      $display("FAIL blk_wr_behind_rd: got %h want %h", {data_addr_ok, arid, araddr, awvalid}, {1'b0, 4'd1, 32'h3000, 1'b0});
    end
    data_req = 0; data_wr = 0;
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rid = 1; rdata = 32'h1234_5678; rlast = 1;
    #1;
    n_cmp++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL blk_rd_beat: got %h want %h", {data_data_ok, data_rdata}, {1'b1, 32'h1234_5678});
    end
    step();
    rvalid = 0; rlast = 0; rid = 0;
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_burst = 1; inst_addr = 32'h1c00_0080;
    step();
    inst_req = 0; inst_burst = 0;
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rid = 0; rdata = 32'haa;
    #1;
    n_cmp++;
    if (inst_data_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_beat: got %b want 1", inst_data_ok);
    end
    reset = 1;
    step();
    reset = 0;
    #1;
    n_cmp++;
    if ({rready, arvalid, inst_data_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_clear: got %b want 000", {rready, arvalid, inst_data_ok});
    end
    step();
    n_cmp++;
    if ({rready, inst_data_ok, data_data_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_after: got %b want 000", {rready, inst_data_ok, data_data_ok});
    end
    rvalid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_burst();
    test_write();
    test_concurrent();
    test_rd_blocked();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
